ifetch_multi_data_stage: RTL and testbench

Parametrised instruction-fetch data stage: the second stage of the instruction pipeline, between the fetch tag stage and instruction decode. It resolves the way hit and reads the L1I data SRAM. It returns up to FETCH_WIDTH consecutive instructions per cycle and detects alignment, TLB and permission faults. It tracks outstanding I-cache misses per thread so that several threads missing on the same line produce a single L2 request, and all of them are woken on the fill.

---
 rtl/ifetch_multi_data_stage_if.sv | 78 +++++++
 rtl/ifetch_multi_data_stage.sv | 152 +++++++++++++++
 tb/tb_ifetch_multi_data_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_multi_data_stage_if.sv
// ifetch_multi_data_stage_if: tag-stage, fill, control and decode-side signals of the fetch data stage
interface ifetch_multi_data_stage_if #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int LINE_WORDS = 16,
  parameter int NUM_THREADS = 4,
  parameter int FETCH_WIDTH = 2
);
  localparam int OFS = $clog2(LINE_WORDS * 4);
  localparam int SETW = $clog2(NUM_SETS);
  localparam int TAGW = 32 - OFS - SETW;
  localparam int TW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1;
  localparam int WAYW = $clog2(NUM_WAYS);
  logic ift_instruction_requested;
  logic [31:0] ift_pc_paddr;
  logic [31:0] ift_pc_vaddr;
  logic [TW-1:0] ift_thread_idx;
  logic ift_tlb_hit;
  logic ift_tlb_present;
  logic ift_tlb_executable;
  logic ift_tlb_supervisor;
  logic [NUM_WAYS-1:0][TAGW-1:0] ift_tag;
  logic [NUM_WAYS-1:0] ift_valid;
  logic [NUM_THREADS-1:0] cr_supervisor_en;
  logic wb_rollback_en;
  logic [TW-1:0] wb_rollback_thread_idx;
  logic [NUM_WAYS-1:0] l2i_itag_update_en;
  logic [SETW-1:0] l2i_itag_update_set;
  logic [TAGW-1:0] l2i_itag_update_tag;
  logic l2i_idata_update_en;
  logic [WAYW-1:0] l2i_idata_update_way;
  logic [SETW-1:0] l2i_idata_update_set;
  logic [32*LINE_WORDS-1:0] l2i_idata_update_data;
  logic ifd_update_lru_en;
  logic [WAYW-1:0] ifd_update_lru_way;
  logic ifd_near_miss;
  logic ifd_cache_miss;
  logic [TAGW+SETW-1:0] ifd_cache_miss_paddr;
  logic [TW-1:0] ifd_cache_miss_thread_idx;
  logic [NUM_THREADS-1:0] ifd_wake_mask;
  logic [FETCH_WIDTH-1:0][31:0] ifd_instruction;
  logic [FETCH_WIDTH-1:0] ifd_instruction_valid;
  logic [31:0] ifd_pc;
  logic [TW-1:0] ifd_thread_idx;
  logic ifd_alignment_fault;
  logic ifd_tlb_miss;
  logic ifd_supervisor_fault;
  logic ifd_page_fault;
  logic ifd_executable_fault;
  logic perf_icache_hit;
  logic perf_icache_miss;
  logic perf_itlb_miss;
  logic perf_miss_merged;
  modport slave (
    input ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
    input ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tlb_supervisor,
    input ift_tag, ift_valid, cr_supervisor_en, wb_rollback_en, wb_rollback_thread_idx,
    input l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag,
    input l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, l2i_idata_update_data,
    output ifd_update_lru_en, ifd_update_lru_way, ifd_near_miss,
    output ifd_cache_miss, ifd_cache_miss_paddr, ifd_cache_miss_thread_idx, ifd_wake_mask,
    output ifd_instruction, ifd_instruction_valid, ifd_pc, ifd_thread_idx,
    output ifd_alignment_fault, ifd_tlb_miss, ifd_supervisor_fault, ifd_page_fault, ifd_executable_fault,
    output perf_icache_hit, perf_icache_miss, perf_itlb_miss, perf_miss_merged
  );
  modport master (
    output ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
    output ift_tlb_hit, ift_tlb_present, ift_tlb_executable, ift_tlb_supervisor,
    output ift_tag, ift_valid, cr_supervisor_en, wb_rollback_en, wb_rollback_thread_idx,
    output l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag,
    output l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, l2i_idata_update_data,
    input ifd_update_lru_en, ifd_update_lru_way, ifd_near_miss,
    input ifd_cache_miss, ifd_cache_miss_paddr, ifd_cache_miss_thread_idx, ifd_wake_mask,
    input ifd_instruction, ifd_instruction_valid, ifd_pc, ifd_thread_idx,
    input ifd_alignment_fault, ifd_tlb_miss, ifd_supervisor_fault, ifd_page_fault, ifd_executable_fault,
    input perf_icache_hit, perf_icache_miss, perf_itlb_miss, perf_miss_merged
  );
endinterface

// File: rtl/ifetch_multi_data_stage.sv
// ifetch_multi_data_stage: way-hit resolve, L1I data read, fault detection and per-thread miss merging
module ifetch_multi_data_stage #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int LINE_WORDS = 16,
  parameter int NUM_THREADS = 4,
  parameter int FETCH_WIDTH = 2
) (
  input logic clk,
  input logic reset,
  ifetch_multi_data_stage_if.slave bus
);
  localparam int OFS = $clog2(LINE_WORDS * 4);
  localparam int SETW = $clog2(NUM_SETS);
  localparam int TAGW = 32 - OFS - SETW;
  localparam int TW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1;
  localparam int WAYW = $clog2(NUM_WAYS);
  localparam int WOW = $clog2(LINE_WORDS);
  localparam int LW = TAGW + SETW;
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  logic req, rb, g, align, cache_hit, slot0, fill, miss_any, new_miss, near, merged;
  logic [TAGW-1:0] ptag;
  logic [SETW-1:0] pset;
  logic [WOW-1:0] w0, w0_q;
  logic [LW-1:0] req_line, fill_line;
  logic [NUM_WAYS-1:0] way_hit;
  logic [WAYW-1:0] hit_way;
  logic [FETCH_WIDTH-1:0] vld_d;
  logic [32*LINE_WORDS-1:0] mem [NUM_WAYS*NUM_SETS];
  logic [32*LINE_WORDS-1:0] rd_data;
  logic [WAYW+SETW-1:0] raddr, waddr;
  logic [31:0] words [LINE_WORDS];
  logic [NUM_THREADS-1:0] pend, clr, hit_other;
  logic [LW-1:0] lines [NUM_THREADS];
  assign req = bus.ift_instruction_requested;
  assign rb = bus.wb_rollback_en && bus.wb_rollback_thread_idx == bus.ift_thread_idx;
  assign g = req && !rb;
  assign ptag = bus.ift_pc_paddr[31 -: TAGW];
  assign pset = bus.ift_pc_paddr[OFS +: SETW];
  assign w0 = bus.ift_pc_paddr[OFS-1:2];
  assign align = bus.ift_pc_paddr[1:0] != 2'b00;
  assign req_line = {ptag, pset};
  assign fill_line = {bus.l2i_itag_update_tag, bus.l2i_itag_update_set};
  assign fill = |bus.l2i_itag_update_en;
  // compare every way's tag against the physical PC tag and encode the hitting way
  always_comb begin
    way_hit = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_hit[w] = bus.ift_valid[w] && bus.ift_tag[w] == ptag;
      if (way_hit[w]) hit_way = WAYW'(w);
    end
  end
  assign cache_hit = |way_hit && bus.ift_tlb_hit;
  assign slot0 = g && cache_hit && !align;
  assign miss_any = req && bus.ift_tlb_hit && !cache_hit;
  assign near = miss_any && fill && fill_line == req_line;
  assign new_miss = miss_any && !near;
  assign raddr = {hit_way, pset};
  assign waddr = {bus.l2i_idata_update_way, bus.l2i_idata_update_set};
  // data SRAM write port, driven by L2 line fills
  always_ff @(posedge clk) begin
    if (bus.l2i_idata_update_en) mem[waddr] <= bus.l2i_idata_update_data;
  end
  // data SRAM read port; a same-cycle write to the read entry forwards the new line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else if (req && cache_hit) rd_data <= bus.l2i_idata_update_en && waddr == raddr ? bus.l2i_idata_update_data : mem[raddr];
  end
  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
    assign words[i] = bswap(rd_data[32*(LINE_WORDS-1-i) +: 32]);
  end
  // slots past the end of the line are invalid; fetches never cross a line
  always_comb begin
    vld_d = '0;
    for (int k = 0; k < FETCH_WIDTH; k++)
      vld_d[k] = slot0 && ({1'b0, w0} + (WOW+1)'(k)) < (WOW+1)'(LINE_WORDS);
  end
  // pick FETCH_WIDTH consecutive words starting at the registered PC word
  always_comb begin
    bus.ifd_instruction = '0;
    for (int k = 0; k < FETCH_WIDTH; k++)
      bus.ifd_instruction[k] = words[w0_q + WOW'(k)];
  end
  // stage output register: slot valids, PC, thread and faults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w0_q <= '0;
      bus.ifd_instruction_valid <= '0;
      bus.ifd_pc <= '0;
      bus.ifd_thread_idx <= '0;
      bus.ifd_alignment_fault <= 1'b0;
      bus.ifd_tlb_miss <= 1'b0;
      bus.ifd_page_fault <= 1'b0;
      bus.ifd_executable_fault <= 1'b0;
      bus.ifd_supervisor_fault <= 1'b0;
    end else begin
      w0_q <= w0;
      bus.ifd_instruction_valid <= vld_d;
      bus.ifd_pc <= bus.ift_pc_vaddr;
      bus.ifd_thread_idx <= bus.ift_thread_idx;
      bus.ifd_alignment_fault <= g && align;
      bus.ifd_tlb_miss <= g && !bus.ift_tlb_hit;
      bus.ifd_page_fault <= g && bus.ift_tlb_hit && !bus.ift_tlb_present;
      bus.ifd_executable_fault <= g && bus.ift_tlb_hit && bus.ift_tlb_present && !bus.ift_tlb_executable;
      bus.ifd_supervisor_fault <= g && bus.ift_tlb_hit && bus.ift_tlb_supervisor && !bus.cr_supervisor_en[bus.ift_thread_idx];
    end
  end
  // match pending entries against the fill line (to clear) and the request line (to merge)
  always_comb begin
    clr = '0;
    hit_other = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      clr[t] = fill && pend[t] && lines[t] == fill_line;
      hit_other[t] = pend[t] && lines[t] == req_line && TW'(t) != bus.ift_thread_idx;
    end
  end
  assign merged = |hit_other;
  // miss table update; a fill clears matching entries while a new miss sets the requester's entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      bus.ifd_wake_mask <= '0;
      for (int t = 0; t < NUM_THREADS; t++) lines[t] <= '0;
    end else begin
      bus.ifd_wake_mask <= clr;
      for (int t = 0; t < NUM_THREADS; t++) begin
        pend[t] <= (pend[t] && !clr[t]) || (new_miss && bus.ift_thread_idx == TW'(t));
        if (new_miss && bus.ift_thread_idx == TW'(t)) lines[t] <= req_line;
      end
    end
  end
  // catch illegal tag-array contents and a second miss from an already-waiting thread
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!req || $onehot0(way_hit)) else $error("multiple ways hit");
      assert (!new_miss || !pend[bus.ift_thread_idx]) else $error("miss from thread with pending miss");
    end
  end
  assign bus.ifd_update_lru_en = req && cache_hit;
  assign bus.ifd_update_lru_way = hit_way;
  assign bus.ifd_near_miss = near;
  assign bus.ifd_cache_miss = new_miss && !merged;
  assign bus.ifd_cache_miss_paddr = req_line;
  assign bus.ifd_cache_miss_thread_idx = bus.ift_thread_idx;
  assign bus.perf_icache_hit = req && cache_hit;
  assign bus.perf_icache_miss = miss_any;
  assign bus.perf_itlb_miss = req && !bus.ift_tlb_hit;
  assign bus.perf_miss_merged = new_miss && merged;
endmodule

// File: tb/tb_ifetch_multi_data_stage.sv
// tb_ifetch_multi_data_stage: directed checks of hit data, faults, miss merging, near miss and reset
module tb_ifetch_multi_data_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  ifetch_multi_data_stage_if bus ();
  ifetch_multi_data_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [1:0] th, input logic [31:0] pa);
    bus.ift_instruction_requested = 1'b1;
    bus.ift_thread_idx = th;
    bus.ift_pc_paddr = pa;
    bus.ift_pc_vaddr = pa;
    bus.ift_tlb_hit = 1'b1;
    bus.ift_tlb_present = 1'b1;
    bus.ift_tlb_executable = 1'b1;
    bus.ift_tlb_supervisor = 1'b0;
    bus.wb_rollback_en = 1'b0;
  endtask
  task automatic tag_fill(input logic en, input logic [19:0] tg);
    bus.l2i_itag_update_en = en ? 4'b0001 : 4'b0000;
    bus.l2i_itag_update_set = '0;
    bus.l2i_itag_update_tag = tg;
  endtask
  initial begin
    logic [511:0] line;
    for (int i = 0; i < 16; i++) line[32*(15-i) +: 32] = 32'h11223300 | i;
    bus.ift_instruction_requested = 1'b0;
    bus.ift_pc_paddr = '0;
    bus.ift_pc_vaddr = '0;
    bus.ift_thread_idx = '0;
    bus.ift_tlb_hit = 1'b0;
    bus.ift_tlb_present = 1'b0;
    bus.ift_tlb_executable = 1'b0;
    bus.ift_tlb_supervisor = 1'b0;
    bus.ift_tag = '0;
    bus.ift_tag[2] = 20'h1;
    bus.ift_valid = 4'b0100;
    bus.cr_supervisor_en = '0;
    bus.wb_rollback_en = 1'b0;
    bus.wb_rollback_thread_idx = '0;
    tag_fill(1'b0, 20'h0);
    bus.l2i_idata_update_en = 1'b0;
    bus.l2i_idata_update_way = '0;
    bus.l2i_idata_update_set = '0;
    bus.l2i_idata_update_data = '0;
    step();
    step();
    chk("rst_valid", 64'(bus.ifd_instruction_valid), 64'h0);
    chk("rst_wake", 64'(bus.ifd_wake_mask), 64'h0);
    chk("rst_instr", 64'(bus.ifd_instruction), 64'h0);
    reset = 1'b0;
    bus.l2i_idata_update_en = 1'b1;
    bus.l2i_idata_update_way = 2'd2;
    bus.l2i_idata_update_data = line;
    step();
    bus.l2i_idata_update_en = 1'b0;
    fetch(2'd0, 32'h1008);
    #1;
    chk("lru_en", 64'(bus.ifd_update_lru_en), 64'h1);
    chk("lru_way", 64'(bus.ifd_update_lru_way), 64'h2);
    chk("perf_hit", 64'(bus.perf_icache_hit), 64'h1);
    chk("hit_no_miss", 64'(bus.ifd_cache_miss), 64'h0);
    step();
    chk("hit_instr", 64'(bus.ifd_instruction), 64'h03332211_02332211);
    chk("hit_valid", 64'(bus.ifd_instruction_valid), 64'h3);
    chk("hit_pc", 64'(bus.ifd_pc), 64'h1008);
    fetch(2'd0, 32'h103C);
    step();
    chk("w15_valid", 64'(bus.ifd_instruction_valid), 64'h1);
    chk("w15_instr", 64'(bus.ifd_instruction[0]), 64'h0F332211);
    fetch(2'd0, 32'h1002);
    step();
    chk("align_fault", 64'(bus.ifd_alignment_fault), 64'h1);
    chk("align_valid", 64'(bus.ifd_instruction_valid), 64'h0);
    fetch(2'd0, 32'h1008);
    bus.ift_tlb_present = 1'b0;
    step();
    chk("page_fault", 64'(bus.ifd_page_fault), 64'h1);
    chk("align_clear", 64'(bus.ifd_alignment_fault), 64'h0);
    fetch(2'd0, 32'h1008);
    bus.ift_tlb_executable = 1'b0;
    step();
    chk("exec_fault", 64'(bus.ifd_executable_fault), 64'h1);
    chk("page_clear", 64'(bus.ifd_page_fault), 64'h0);
    fetch(2'd2, 32'h1008);
    bus.ift_tlb_supervisor = 1'b1;
    bus.cr_supervisor_en = 4'b1011;
    step();
    chk("sup_fault", 64'(bus.ifd_supervisor_fault), 64'h1);
    chk("thread_out", 64'(bus.ifd_thread_idx), 64'h2);
    bus.cr_supervisor_en = 4'b0100;
    step();
    chk("sup_ok", 64'(bus.ifd_supervisor_fault), 64'h0);
    fetch(2'd0, 32'h1008);
    bus.ift_tlb_hit = 1'b0;
    #1;
    chk("perf_itlb", 64'(bus.perf_itlb_miss), 64'h1);
    chk("itlb_no_l2", 64'(bus.ifd_cache_miss), 64'h0);
    step();
    chk("tlb_miss", 64'(bus.ifd_tlb_miss), 64'h1);
    chk("tlb_valid", 64'(bus.ifd_instruction_valid), 64'h0);
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd0;
    step();
    chk("rb_tlb_miss", 64'(bus.ifd_tlb_miss), 64'h0);
    chk("rb_valid", 64'(bus.ifd_instruction_valid), 64'h0);
    bus.wb_rollback_thread_idx = 2'd1;
    step();
    chk("rb_other_thread", 64'(bus.ifd_tlb_miss), 64'h1);
    fetch(2'd1, 32'h2000);
    #1;
    chk("miss_l2", 64'(bus.ifd_cache_miss), 64'h1);
    chk("miss_thread", 64'(bus.ifd_cache_miss_thread_idx), 64'h1);
    chk("miss_paddr", 64'(bus.ifd_cache_miss_paddr), 64'h80);
    chk("perf_miss", 64'(bus.perf_icache_miss), 64'h1);
    chk("first_not_merged", 64'(bus.perf_miss_merged), 64'h0);
    step();
    fetch(2'd3, 32'h2000);
    #1;
    chk("merge_no_l2", 64'(bus.ifd_cache_miss), 64'h0);
    chk("merge_perf", 64'(bus.perf_miss_merged), 64'h1);
    step();
    bus.ift_instruction_requested = 1'b0;
    tag_fill(1'b1, 20'h2);
    step();
    tag_fill(1'b0, 20'h0);
    chk("wake_merged", 64'(bus.ifd_wake_mask), 64'hA);
    step();
    chk("wake_pulse_end", 64'(bus.ifd_wake_mask), 64'h0);
    fetch(2'd0, 32'h2000);
    #1;
    chk("cleared_l2", 64'(bus.ifd_cache_miss), 64'h1);
    chk("cleared_merge", 64'(bus.perf_miss_merged), 64'h0);
    step();
    bus.ift_instruction_requested = 1'b0;
    tag_fill(1'b1, 20'h2);
    step();
    tag_fill(1'b0, 20'h0);
    chk("wake_t0", 64'(bus.ifd_wake_mask), 64'h1);
    fetch(2'd2, 32'h3000);
    tag_fill(1'b1, 20'h3);
    #1;
    chk("near_miss", 64'(bus.ifd_near_miss), 64'h1);
    chk("near_no_l2", 64'(bus.ifd_cache_miss), 64'h0);
    step();
    tag_fill(1'b0, 20'h0);
    fetch(2'd0, 32'h3000);
    #1;
    chk("near_no_entry", 64'(bus.ifd_cache_miss), 64'h1);
    step();
    bus.ift_instruction_requested = 1'b0;
    tag_fill(1'b1, 20'h3);
    step();
    tag_fill(1'b0, 20'h0);
    chk("near_wake", 64'(bus.ifd_wake_mask), 64'h1);
    fetch(2'd1, 32'h4000);
    step();
    fetch(2'd2, 32'h5000);
    step();
    fetch(2'd0, 32'h1002);
    step();
    chk("pre_rst_align", 64'(bus.ifd_alignment_fault), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_align", 64'(bus.ifd_alignment_fault), 64'h0);
    chk("arst_valid", 64'(bus.ifd_instruction_valid), 64'h0);
    bus.ift_instruction_requested = 1'b0;
    step();
    reset = 1'b0;
    tag_fill(1'b1, 20'h4);
    step();
    chk("rst_wake4", 64'(bus.ifd_wake_mask), 64'h0);
    tag_fill(1'b1, 20'h5);
    step();
    chk("rst_wake5", 64'(bus.ifd_wake_mask), 64'h0);
    tag_fill(1'b0, 20'h0);
    fetch(2'd1, 32'h4000);
    #1;
    chk("rst_table_empty", 64'(bus.ifd_cache_miss), 64'h1);
    step();
    bus.ift_instruction_requested = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
